// File: rtl/uart_bus_arbiter.sv
// ============================================================================
//  Module   : uart_bus_arbiter
//  Purpose  : Multi-channel UART RX-to-data-memory arbiter with TX store gating.
//             Define ROUND_ROBIN_EN for rotating priority; fixed priority otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bus_arbiter #(
    parameter int                NUM_CH    = 2,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 'h100,
    parameter logic [ADDR_W-1:0] CH_STRIDE = 'h10,
    parameter int                RX_OFFSET = 4,
    localparam int               CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              mem_read_cpu,
    input  logic              mem_write_cpu,
    input  logic [NUM_CH-1:0] rx_ready,
    input  logic [NUM_CH-1:0] tx_busy,
    output logic [NUM_CH-1:0] tx_enable,
    output logic              tx_drop,
    output logic              mem_write_out,
    output logic [ADDR_W-1:0] rx_addr_out,
    output logic [CH_W-1:0]   rx_sel,
    output logic [NUM_CH-1:0] rx_ack,
    output logic [NUM_CH-1:0] overrun,
    input  logic [NUM_CH-1:0] ovr_clear
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t            r_state_q,    w_state_d;
    logic [NUM_CH-1:0] r_pending_q,  w_pending_d;
    logic [NUM_CH-1:0] r_overrun_q,  w_overrun_d;
    logic [NUM_CH-1:0] r_rx_ack_q,   w_rx_ack_d;
    logic [NUM_CH-1:0] r_rx_ready_q;
    logic [CH_W-1:0]   r_rx_sel_q,   w_rx_sel_d;

    logic              w_cpu_busy;
    logic              w_done;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_tx_hit;
    logic [CH_W-1:0]   w_win;

`ifdef ROUND_ROBIN_EN
    logic [CH_W-1:0]   r_prio_q, w_prio_d;
    int                w_idx;

    // Scan downward so the last hit is the closest pending channel at/after prio.
    always_comb begin : p_winner
        w_win = '0;
        w_idx = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = int'(r_prio_q) + k;
            if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            if (r_pending_q[w_idx]) w_win = CH_W'(w_idx);
        end
    end

    always_comb begin : p_prio
        w_prio_d = r_prio_q;
        if (w_done) begin
            w_prio_d = (r_rx_sel_q == CH_W'(NUM_CH - 1)) ? '0 : r_rx_sel_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin : p_prio_reg
        if (rst) r_prio_q <= '0;
        else     r_prio_q <= w_prio_d;
    end
`else
    always_comb begin : p_winner
        w_win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pending_q[i]) w_win = CH_W'(i);
        end
    end
`endif

    always_comb begin : p_next
        w_cpu_busy = mem_read_cpu | mem_write_cpu;
        w_rise     = rx_ready & ~r_rx_ready_q;
        w_done     = (r_state_q == S_WRITE) && !w_cpu_busy;
        for (int i = 0; i < NUM_CH; i++) begin
            w_clr[i] = w_done && (r_rx_sel_q == CH_W'(i));
        end
        // A rise on the channel being retired re-arms it without flagging overrun.
        w_pending_d = (r_pending_q & ~w_clr) | w_rise;
        w_overrun_d = (r_overrun_q & ~ovr_clear) | (w_rise & r_pending_q & ~w_clr);
        w_rx_ack_d  = w_clr;
        w_state_d   = r_state_q;
        w_rx_sel_d  = r_rx_sel_q;
        unique case (r_state_q)
            S_IDLE: begin
                if ((|r_pending_q) && !w_cpu_busy) begin
                    w_rx_sel_d = w_win;
                    w_state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_done) w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_comb begin : p_tx
        for (int i = 0; i < NUM_CH; i++) begin
            w_tx_hit[i] = mem_write_cpu && (address == (BASE_ADDR + ADDR_W'(i) * CH_STRIDE));
        end
        tx_enable = w_tx_hit & ~tx_busy;
        tx_drop   = |(w_tx_hit & tx_busy);
    end

    always_ff @(posedge clk) begin : p_regs
        r_rx_ready_q <= rx_ready;
        if (rst) begin
            r_state_q   <= S_IDLE;
            r_pending_q <= '0;
            r_overrun_q <= '0;
            r_rx_ack_q  <= '0;
            r_rx_sel_q  <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_pending_q <= w_pending_d;
            r_overrun_q <= w_overrun_d;
            r_rx_ack_q  <= w_rx_ack_d;
            r_rx_sel_q  <= w_rx_sel_d;
        end
    end

    assign mem_write_out = w_done;
    assign rx_addr_out   = BASE_ADDR + ADDR_W'(r_rx_sel_q) * CH_STRIDE + ADDR_W'(RX_OFFSET);
    assign rx_sel        = r_rx_sel_q;
    assign rx_ack        = r_rx_ack_q;
    assign overrun       = r_overrun_q;

endmodule

`default_nettype wire
